sdet_rr_scan_ctrl: RTL and testbench
====================================

// Module: sdet_rr_scan_ctrl
// PURPOSE
//  Round-robin scheduler that shares one bit-serial run detector among N requesters.
//  Each requester presents a W-bit word. The controller grants one requester at a time and
//  shifts the granted word MSB-first through the detector. It then reports per-word match
//  results tagged with the requester ID.
//  Sits between parallel producers and the serial detection datapath.
// PARAMETERS
//  N    4  number of requesters (>=2)
//  W    8  word width / bits shifted per grant (>=2)
//  RUN  3  consecutive-ones length that constitutes a match (1..W)
//  IW   $clog2(N)    derived; width of requester ID
//  CW   $clog2(W+1)  derived; width of match counter
// PORTS
//  ck         in   1     clock, all logic on rising edge
//  reset      in   1     reset, synchronous, active-high
//  req        in   N     per-requester request; held until own gnt bit seen
//  data       in   N*W   packed words; requester k in data[k*W +: W]
//  gnt        out  N     one-hot, one-cycle pulse: word of that requester captured
//  busy       out  1     1 while a word is in flight (SHIFT or REPORT)
//  ser_bit    out  1     bit currently presented to detector
//  ser_valid  out  1     1 during each of the W shift cycles
//  done       out  1     one-cycle pulse: result fields valid
//  done_id    out  IW    requester ID of the reported word
//  match      out  1     1 if match_cnt != 0
//  match_cnt  out  CW    number of bit cycles after which run length >= RUN
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, run=0. gnt, busy, ser_bit, ser_valid, done, done_id, match
//    and match_cnt all 0.
//  - FSM states: IDLE, SHIFT, REPORT. All outputs are registered.
//  - IDLE, |req=1: winner = first set req at or after rr_ptr, searching upward with wrap.
//    Actions at that edge:
//    sreg<=data[winner], gnt<=onehot(winner), id<=winner, rr_ptr<=(winner+1)%N.
//    Also bitcnt<=0, run<=0, cnt<=0, state<=SHIFT.
//  - IDLE, |req=0: remain IDLE, all pulses 0.
//  - Requester drops req in the cycle it sees its gnt bit. req is ignored outside IDLE.
//  - SHIFT, W cycles:
//    - ser_valid=1 and ser_bit=sreg[W-1]; sreg shifts left each cycle.
//    - run <= bit ? min(run+1,RUN) : 0.
//    - cnt increments when the updated run==RUN.
//    - Leave to REPORT after bit index W-1.
//  - REPORT, 1 cycle: done=1, done_id=id, match_cnt=cnt, match=(cnt!=0). Next state IDLE.
//  - Latency: gnt at cycle t, first ser_valid at t, done at t+W.
//    Earliest next gnt is t+W+2, so each word occupies W+2 cycles.
//  - done_id, match and match_cnt hold their value until the next done. Pulses last exactly 1 cycle.
//  - Run detection restarts for every word; no run carries across word boundaries.
//  - cnt saturates at W, which is unreachable past W-RUN+1.
//  - Reset mid-SHIFT/REPORT: word abandoned, no done, rr_ptr=0.
//    Requester must re-request; its gnt is not repeated.
//  - Simultaneous requests: exactly one gnt bit per grant, never two.
//  - A requester that keeps req high after gnt is re-granted when its round-robin turn returns.
// STRUCTURE
//  - Shared package sdet_pkg:
//    - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_REPORT=2'd2.
//    - onehot/priority helper functions.
//  - Sub-module sdet_run_core (ck, reset, clr, vld, bit, run_hit):
//    - saturating run counter of width $clog2(RUN+1).
//    - run_hit is asserted when run==RUN.
//  - Top: round-robin arbiter, shift register, bit counter, match counter, FSM.
// TESTING (N=4, W=8, RUN=3)
//  1. req=4'b0010, data[1]=8'b0111_1100:
//     gnt=4'b0010 for 1 cycle; ser_bit 0,1,1,1,1,1,0,0.
//     done 8 cycles after gnt, done_id=1, match=1, match_cnt=3.
//  2. req=4'b0001, data[0]=8'b1101_1011 -> done_id=0, match=0, match_cnt=0.
//     data=8'hFF -> match_cnt=6.
//  3. req=4'b1111 held, each requester dropping on its gnt:
//     grants in order 0,1,2,3, spaced 10 cycles; done_id follows 0,1,2,3.
//  4. After a grant to 2, assert req=4'b1001 -> next grant 3, then 0.
//     busy=1 throughout each word and 0 in the IDLE gap.
//  5. Assert reset at the 4th SHIFT cycle of a grant to 2:
//     - next cycle all outputs 0 and no done;
//     - then req=4'b0101 -> gnt=4'b0001 first.
//  6. RUN=1 build, data=8'b1010_1010 -> match_cnt=4.
//     RUN=8 build, data=8'hFF -> match_cnt=1.

Source files
------------

// File: rtl/sdet_rr_scan_ctrl_pkg.sv
// Shared definitions for the round-robin scan controller.
//  - state_t : FSM state encoding (IDLE/SHIFT/REPORT)
//  - MAXN    : largest requester count the helper functions handle
//  - rr_winner / onehot : round-robin search and one-hot helpers
package sdet_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam int MAXN = 32;

  // First set request at or after ptr, searching upward and wrapping at n.
  // Returns 0 when nothing is set; callers only use it when a request is present.
  function automatic int rr_winner(input logic [MAXN-1:0] req, input int ptr, input int n);
    int  win;
    int  idx;
    logic found;
    win   = 0;
    idx   = 0;
    found = 1'b0;
    for (int k = 0; k < MAXN; k++) begin
      if (k < n && !found) begin
        idx = (ptr + k) % n;
        if (req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

  function automatic logic [MAXN-1:0] onehot(input int idx);
    logic [MAXN-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sdet_rr_scan_ctrl_if.sv
// Bus between parallel producers and the scan controller.
//  master: producer side (drives req/data, observes grant and results)
//  slave : controller side
// Handshake: a requester raises req[k] with its word on data[k*W +: W] and holds
// both until it sees gnt[k] (one-cycle pulse); the word is captured at that edge
// and the requester drops req[k] in the same cycle. done is a one-cycle pulse;
// done_id/match/match_cnt hold until the next done. dbg_state shows the FSM state.
interface sdet_rr_scan_ctrl_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(W + 1);

  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           ser_bit;
  logic           ser_valid;
  logic           done;
  logic [IW-1:0]  done_id;
  logic           match;
  logic [CW-1:0]  match_cnt;
  logic [1:0]     dbg_state;

  modport master (
    output req, data,
    input  gnt, busy, ser_bit, ser_valid, done, done_id, match, match_cnt, dbg_state
  );

  modport slave (
    input  req, data,
    output gnt, busy, ser_bit, ser_valid, done, done_id, match, match_cnt, dbg_state
  );
endinterface

// File: rtl/sdet_rr_scan_ctrl_run_core.sv
// Bit-serial run detector: counts consecutive ones, saturating at RUN.
// Ports:
//  ck, reset   : clock, synchronous active-high reset
//  i_clr       : restart run tracking (held while the controller is idle)
//  i_vld       : i_bit is a valid serial bit this cycle
//  i_bit       : serial data bit
//  o_run_hit   : this bit brings the run length to RUN (combinational on the
//                updated value so the controller can fold it into the same edge)
module sdet_run_core #(
  parameter int RUN = 3
) (
  input  logic ck,
  input  logic reset,
  input  logic i_clr,
  input  logic i_vld,
  input  logic i_bit,
  output logic o_run_hit
);
  localparam int RW = $clog2(RUN + 1);
  localparam logic [RW-1:0] RUN_V = RW'(RUN);

  logic [RW-1:0] r_run;
  logic [RW-1:0] w_inc;

  assign w_inc     = (r_run == RUN_V) ? r_run : r_run + 1'b1;
  assign o_run_hit = i_vld & i_bit & (w_inc == RUN_V);

  always_ff @(posedge ck) begin
    if (reset || i_clr) begin
      r_run <= '0;
    end else if (i_vld) begin
      r_run <= i_bit ? w_inc : '0;
    end
  end
endmodule

// File: rtl/sdet_rr_scan_ctrl.sv
// Round-robin scheduler sharing one bit-serial run detector among N requesters.
// Grants one requester, shifts its W-bit word MSB-first through sdet_run_core,
// then reports the per-word match count tagged with the requester ID.
// Ports:
//  ck    : clock (rising edge)
//  reset : synchronous, active-high
//  bus   : slave side of sdet_rr_scan_ctrl_if (req/data in; gnt, busy,
//          ser_bit, ser_valid, done, done_id, match, match_cnt, dbg_state out)
// Timing: gnt and the first ser_valid appear in the same cycle t, done at t+W,
// earliest next gnt at t+W+2.
module sdet_rr_scan_ctrl
  import sdet_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int RUN = 3
) (
  input  logic ck,
  input  logic reset,
  sdet_rr_scan_ctrl_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(W + 1);
  localparam int BW = $clog2(W);

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_id;
  logic [W-1:0]  r_sreg;
  logic [BW-1:0] r_bitcnt;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_gnt;
  logic          r_busy;
  logic          r_ser_bit;
  logic          r_ser_valid;
  logic          r_done;
  logic [IW-1:0] r_done_id;
  logic          r_match;
  logic [CW-1:0] r_match_cnt;

  logic          w_any;
  logic [IW-1:0] w_win;
  logic [W-1:0]  w_word;
  logic          w_run_hit;
  logic [CW-1:0] w_cnt_next;

  assign w_any  = |bus.req;
  assign w_win  = IW'(rr_winner(MAXN'(bus.req), int'(r_ptr), N));
  assign w_word = bus.data[w_win*W +: W];

  // Match counter saturates at W (never reached in practice).
  assign w_cnt_next = w_run_hit ? ((r_cnt == CW'(W)) ? r_cnt : r_cnt + 1'b1) : r_cnt;

  // The detector sees the bit currently on ser_bit; it is cleared while idle
  // so every word starts from a zero run.
  sdet_run_core #(.RUN(RUN)) u_run_core (
    .ck        (ck),
    .reset     (reset),
    .i_clr     (r_state == S_IDLE),
    .i_vld     (r_state == S_SHIFT),
    .i_bit     (r_ser_bit),
    .o_run_hit (w_run_hit)
  );

  always_ff @(posedge ck) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_sreg      <= '0;
      r_bitcnt    <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_ser_bit   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_match     <= 1'b0;
      r_match_cnt <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            // MSB goes straight onto ser_bit; sreg keeps the remaining bits.
            r_ser_bit   <= w_word[W-1];
            r_ser_valid <= 1'b1;
            r_sreg      <= w_word << 1;
            r_gnt       <= N'(onehot(int'(w_win)));
            r_id        <= w_win;
            r_ptr       <= (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
            r_bitcnt    <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_cnt <= w_cnt_next;
          if (r_bitcnt == BW'(W - 1)) begin
            r_ser_valid <= 1'b0;
            r_ser_bit   <= 1'b0;
            r_done      <= 1'b1;
            r_done_id   <= r_id;
            r_match_cnt <= w_cnt_next;
            r_match     <= (w_cnt_next != '0);
            r_state     <= S_REPORT;
          end else begin
            r_ser_bit <= r_sreg[W-1];
            r_sreg    <= r_sreg << 1;
            r_bitcnt  <= r_bitcnt + 1'b1;
          end
        end
        S_REPORT: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = r_busy;
  assign bus.ser_bit   = r_ser_bit;
  assign bus.ser_valid = r_ser_valid;
  assign bus.done      = r_done;
  assign bus.done_id   = r_done_id;
  assign bus.match     = r_match;
  assign bus.match_cnt = r_match_cnt;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_sdet_rr_scan_ctrl.sv
// Bench for sdet_rr_scan_ctrl (N=4, W=8) with RUN=3, plus RUN=1 and RUN=8 builds.
module tb_sdet_rr_scan_ctrl;

  logic ck = 1'b0;
  logic reset = 1'b1;
  always #5 ck = ~ck;

  sdet_rr_scan_ctrl_if #(.N(4), .W(8)) bus ();
  sdet_rr_scan_ctrl_if #(.N(4), .W(8)) b1 ();
  sdet_rr_scan_ctrl_if #(.N(4), .W(8)) b8 ();

  sdet_rr_scan_ctrl #(.N(4), .W(8), .RUN(3)) dut    (.ck(ck), .reset(reset), .bus(bus));
  sdet_rr_scan_ctrl #(.N(4), .W(8), .RUN(1)) dut_r1 (.ck(ck), .reset(reset), .bus(b1));
  sdet_rr_scan_ctrl #(.N(4), .W(8), .RUN(8)) dut_r8 (.ck(ck), .reset(reset), .bus(b8));

  typedef struct {
    logic        load;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_id;
    logic        exp_match;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       bus.gnt, 0);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_ser_bit"},   bus.ser_bit, 0);
    check({tag, "_ser_valid"}, bus.ser_valid, 0);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_done_id"},   bus.done_id, 0);
    check({tag, "_match"},     bus.match, 0);
    check({tag, "_match_cnt"}, bus.match_cnt, 0);
    check({tag, "_state"},     bus.dbg_state, 0);
  endtask

  // Apply one vector: wait for its grant (expected on the first edge), follow
  // the W shift cycles bit by bit, then check the report and the idle gap.
  task automatic run_vec(input vec_t v);
    int waited;
    logic got;
    logic [7:0] word;
    logic [7:0] e;
    if (v.load) begin
      bus.req  = v.req;
      bus.data = v.data;
    end
    waited = 0;
    got = 1'b0;
    while (!got && waited < 20) begin
      tick();
      waited++;
      if (bus.gnt != 0) got = 1'b1;
    end
    check("gnt_seen", got, 1);
    if (!got) return;
    check("gnt_latency", waited, 1);
    check("gnt", bus.gnt, v.exp_gnt);
    exp_q.push_back({1'b0, v.exp_id, v.exp_match, v.exp_cnt});
    word = bus.data[v.exp_id*8 +: 8];
    bus.req = bus.req & ~bus.gnt;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        tick();
        check("gnt_pulse", bus.gnt, 0);
      end
      check("ser_valid", bus.ser_valid, 1);
      check("ser_bit", bus.ser_bit, word[7-i]);
      check("busy_shift", bus.busy, 1);
      check("done_early", bus.done, 0);
    end
    tick();
    check("done", bus.done, 1);
    check("busy_report", bus.busy, 1);
    check("ser_valid_report", bus.ser_valid, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check("done_fields", {1'b0, bus.done_id, bus.match, bus.match_cnt}, e);
    tick();
    check("done_pulse", bus.done, 0);
    check("busy_idle", bus.busy, 0);
    check("fields_hold", {1'b0, bus.done_id, bus.match, bus.match_cnt}, e);
  endtask

  initial begin
    int   waited;
    logic got;
    logic saw_done;
    logic d1, d8;
    logic [3:0] c1, c8;
    logic m1, m8;

    //              load  req      data           gnt      id    m     cnt
    vecs[0]  = '{1'b1, 4'b0010, 32'h0000_7C00, 4'b0010, 2'd1, 1'b1, 4'd3};
    vecs[1]  = '{1'b1, 4'b0001, 32'h0000_00DB, 4'b0001, 2'd0, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 4'b0001, 32'h0000_00FF, 4'b0001, 2'd0, 1'b1, 4'd6};
    vecs[3]  = '{1'b1, 4'b1000, 32'hE700_0000, 4'b1000, 2'd3, 1'b1, 4'd2};
    vecs[4]  = '{1'b1, 4'b1111, 32'hF000_E00F, 4'b0001, 2'd0, 1'b1, 4'd2};
    vecs[5]  = '{1'b0, 4'b0000, 32'h0,         4'b0010, 2'd1, 1'b1, 4'd1};
    vecs[6]  = '{1'b0, 4'b0000, 32'h0,         4'b0100, 2'd2, 1'b0, 4'd0};
    vecs[7]  = '{1'b0, 4'b0000, 32'h0,         4'b1000, 2'd3, 1'b1, 4'd2};
    vecs[8]  = '{1'b1, 4'b0100, 32'h00B6_0000, 4'b0100, 2'd2, 1'b0, 4'd0};
    vecs[9]  = '{1'b1, 4'b1001, 32'h7700_0038, 4'b1000, 2'd3, 1'b1, 4'd2};
    vecs[10] = '{1'b0, 4'b0000, 32'h0,         4'b0001, 2'd0, 1'b1, 4'd1};
    vecs[11] = '{1'b1, 4'b0101, 32'h0000_001C, 4'b0001, 2'd0, 1'b1, 4'd1};
    vecs[12] = '{1'b0, 4'b0000, 32'h0,         4'b0100, 2'd2, 1'b0, 4'd0};

    bus.req = '0; bus.data = '0;
    b1.req  = '0; b1.data  = '0;
    b8.req  = '0; b8.data  = '0;
    reset = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check_all_zero("idle_no_req");

    for (int i = 0; i <= 10; i++) run_vec(vecs[i]);

    // Reset in the 4th SHIFT cycle of a grant to requester 2.
    bus.req  = 4'b0100;
    bus.data = 32'h00FF_0000;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 20) begin
      tick();
      waited++;
      if (bus.gnt != 0) got = 1'b1;
    end
    check("rst_seq_gnt", bus.gnt, 4'b0100);
    bus.req = '0;
    repeat (3) tick();
    check("rst_seq_in_shift", bus.ser_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("mid_reset");
    saw_done = 1'b0;
    repeat (12) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    check("no_done_after_reset", saw_done, 0);
    run_vec(vecs[11]);
    run_vec(vecs[12]);

    // RUN=1 and RUN=8 builds side by side.
    b1.data = 32'h0000_00AA;
    b8.data = 32'h0000_00FF;
    b1.req  = 4'b0001;
    b8.req  = 4'b0001;
    d1 = 1'b0; d8 = 1'b0; c1 = '0; c8 = '0; m1 = 1'b0; m8 = 1'b0;
    repeat (20) begin
      tick();
      if (b1.gnt != 0) b1.req = '0;
      if (b8.gnt != 0) b8.req = '0;
      if (b1.done) begin d1 = 1'b1; c1 = b1.match_cnt; m1 = b1.match; end
      if (b8.done) begin d8 = 1'b1; c8 = b8.match_cnt; m8 = b8.match; end
    end
    check("run1_done", d1, 1);
    check("run1_cnt", c1, 4);
    check("run1_match", m1, 1);
    check("run8_done", d8, 1);
    check("run8_cnt", c8, 1);
    check("run8_match", m8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
